bat_reg_bank: RTL

//  Parametrised general-purpose register bank for the BatAmateur datapath. Replaces the
//  per-register bidi instances (A, B, THREE..SEVEN) with one indexed bank, and replaces the

---
 rtl/bat_pkg.sv | 27 ++
 rtl/bat_out_fifo.sv | 80 ++++++++
 rtl/bat_reg_bank.sv | 84 ++++++++
 3 files changed

// File: rtl/bat_pkg.sv
// Shared constants for the BatAmateur datapath: bus width, register indices
// and a clog2 helper for select and pointer widths.
package bat_pkg;

    localparam int BAT_WIDTH = 16;

    localparam int REG_A     = 0;
    localparam int REG_B     = 1;
    localparam int REG_THREE = 2;
    localparam int REG_FOUR  = 3;
    localparam int REG_FIVE  = 4;
    localparam int REG_SIX   = 5;
    localparam int REG_SEVEN = 6;

    // Never returns less than 1, so a depth-1 structure still gets a 1-bit pointer.
    function automatic int clog2(input int n);
        int r;
        r = 1;
        for (int i = 1; i < 31; i++) begin
            if ((1 << i) < n) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/bat_out_fifo.sv
// Output FIFO for the register bank: circular buffer with first-word fall-through head,
// valid/ready pop, occupancy level and a sticky overflow flag.
module bat_out_fifo
    import bat_pkg::*;
#(
    parameter int WIDTH = BAT_WIDTH,
    parameter int DEPTH = 4,
    parameter int LVL_W = 3
) (
    input  logic             clk,
    input  logic             srst,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    output logic [WIDTH-1:0] data_o,
    output logic             valid_o,
    input  logic             ready_i,
    output logic [LVL_W-1:0] level_o,
    output logic             ovf_o
);

    localparam int PTR_W = clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [LVL_W-1:0] count_q;
    logic [LVL_W-1:0] count_d;
    logic [WIDTH-1:0] last_q;
    logic             ovf_q;
    logic             pop;
    logic             push;

    assign pop  = (count_q != '0) && ready_i;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign push = push_i && ((count_q < LVL_W'(DEPTH)) || pop);

    always_comb begin
        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + LVL_W'(1);
        end else if (pop && !push) begin
            count_d = count_q - LVL_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            last_q   <= '0;
            ovf_q    <= 1'b0;
        end else begin
            count_q <= count_d;
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
                last_q   <= mem_q[rd_ptr_q];
            end
            if (push_i && !push) begin
                ovf_q <= 1'b1;
            end
        end
    end

    // While empty the head shows the most recently consumed word.
    assign data_o  = (count_q != '0) ? mem_q[rd_ptr_q] : last_q;
    assign valid_o = (count_q != '0);
    assign level_o = count_q;
    assign ovf_o   = ovf_q;

endmodule

// File: rtl/bat_reg_bank.sv
// Indexed general-purpose register bank with combinational bus read, write/count
// arbitration and a buffered valid/ready output port.
module bat_reg_bank
    import bat_pkg::*;
#(
    parameter int WIDTH     = BAT_WIDTH,
    parameter int NUM_REGS  = 8,
    parameter int SEL_W     = 3,
    parameter int OUT_DEPTH = 4
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [WIDTH-1:0] BUS_IN,
    output logic [WIDTH-1:0] BUS_OUT,
    output logic             BUS_OE,
    input  logic             WR_EN,
    input  logic [SEL_W-1:0] WR_SEL,
    input  logic             RD_EN,
    input  logic [SEL_W-1:0] RD_SEL,
    input  logic             CNT_EN,
    input  logic [SEL_W-1:0] CNT_SEL,
    input  logic             CNT_DOWN,
    output logic [WIDTH-1:0] ALU_A,
    output logic [WIDTH-1:0] ALU_B,
    input  logic             OUT_PUSH,
    output logic [WIDTH-1:0] OUT_DATA,
    output logic             OUT_VALID,
    input  logic             OUT_READY,
    output logic [SEL_W:0]   OUT_LEVEL,
    output logic             OUT_OVF
);

    logic [WIDTH-1:0] regs_q [NUM_REGS];
    logic [WIDTH-1:0] bus_out_d;

    // Selects beyond NUM_REGS match no register, so such writes and counts fall away.
    generate
        for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_reg
            always_ff @(posedge CLK) begin
                if (RST) begin
                    regs_q[gi] <= '0;
                end else if (WR_EN && (WR_SEL == SEL_W'(gi))) begin
                    regs_q[gi] <= BUS_IN;
                end else if (CNT_EN && (CNT_SEL == SEL_W'(gi))) begin
                    regs_q[gi] <= CNT_DOWN ? (regs_q[gi] - WIDTH'(1))
                                           : (regs_q[gi] + WIDTH'(1));
                end
            end
        end
    endgenerate

    always_comb begin
        bus_out_d = '0;
        if (RD_EN) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (RD_SEL == SEL_W'(i)) begin
                    bus_out_d = regs_q[i];
                end
            end
        end
    end

    assign BUS_OUT = bus_out_d;
    assign BUS_OE  = RD_EN;
    assign ALU_A   = regs_q[REG_A];
    assign ALU_B   = regs_q[REG_B];

    bat_out_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (OUT_DEPTH),
        .LVL_W (SEL_W + 1)
    ) u_out_fifo (
        .clk     (CLK),
        .srst    (RST),
        .push_i  (OUT_PUSH),
        .data_i  (BUS_IN),
        .data_o  (OUT_DATA),
        .valid_o (OUT_VALID),
        .ready_i (OUT_READY),
        .level_o (OUT_LEVEL),
        .ovf_o   (OUT_OVF)
    );

endmodule
